// File: rtl/fir_mac_sequencer_pkg.sv
// Shared types and constants for the FIR MAC sequencer (package fir_seq_pkg).
// Optional build macro used by the top: FIR_SEQ_STICKY_FLAGS_EN.
package fir_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [31:0] FP32_ZERO   = 32'h0000_0000;
  localparam int          FP32_SIGN_W = 1;
  localparam int          FP32_EXP_W  = 8;
  localparam int          FP32_MAN_W  = 23;

  // {invalid, overflow, underflow}
  typedef logic [2:0] flags_t;

  function automatic flags_t pack_flags(input logic invalid, input logic overflow,
                                        input logic underflow);
    return {invalid, overflow, underflow};
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample stream, coefficient port, MAC link and result stream of the FIR sequencer.
// The master modport is the sequencer side; slave is the surrounding system.
interface fir_mac_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
);
  logic                  s_valid_i;
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_ready_o;
  logic                  coef_we_i;
  logic [ADDR_WIDTH-1:0] coef_addr_i;
  logic [DATA_WIDTH-1:0] coef_data_i;
  logic                  coef_busy_o;
  logic                  mac_ce_o;
  logic [DATA_WIDTH-1:0] x_o;
  logic [DATA_WIDTH-1:0] h_o;
  logic                  fpopmode_bit_o;
  logic [DATA_WIDTH-1:0] y_i;
  logic                  invalid_i;
  logic                  overflow_i;
  logic                  underflow_i;
  logic                  m_valid_o;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_invalid_o;
  logic                  m_overflow_o;
  logic                  m_underflow_o;
  logic                  m_ready_i;

  modport master (
    input  s_valid_i, s_data_i, coef_we_i, coef_addr_i, coef_data_i,
    input  y_i, invalid_i, overflow_i, underflow_i, m_ready_i,
    output s_ready_o, coef_busy_o, mac_ce_o, x_o, h_o, fpopmode_bit_o,
    output m_valid_o, m_data_o, m_invalid_o, m_overflow_o, m_underflow_o
  );

  modport slave (
    output s_valid_i, s_data_i, coef_we_i, coef_addr_i, coef_data_i,
    output y_i, invalid_i, overflow_i, underflow_i, m_ready_i,
    input  s_ready_o, coef_busy_o, mac_ce_o, x_o, h_o, fpopmode_bit_o,
    input  m_valid_o, m_data_o, m_invalid_o, m_overflow_o, m_underflow_o
  );

endinterface

// File: rtl/fir_mac_sequencer_delay_line.sv
// Sample delay line (fir_delay_line): newest sample at index 0, oldest falls off the end.
// A tap-select mux exposes one stored sample per cycle.
module fir_delay_line
  import fir_seq_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] shift_in,
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic [DATA_WIDTH-1:0] tap
);

  logic [DATA_WIDTH-1:0] d_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) d_reg[i] <= DATA_WIDTH'(FP32_ZERO);
    end else if (shift_en) begin
      d_reg[0] <= shift_in;
      for (int i = 1; i < DEPTH; i++) d_reg[i] <= d_reg[i-1];
    end
  end

  // Guard keeps non-power-of-two depths from reading past the last stage.
  assign tap = ({1'b0, sel} < (SEL_WIDTH+1)'(DEPTH)) ? d_reg[sel] : '0;

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR sequencer feeding one FP32 MAC: delay line, coefficient bank, IDLE/ISSUE/WAIT FSM,
// one-entry result register. Define FIR_SEQ_STICKY_FLAGS_EN for sticky flag accumulation.
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int FILTER_ORDER = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int MAC_LATENCY  = 4,
  parameter int ADDR_WIDTH   = $clog2(FILTER_ORDER)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  fir_mac_sequencer_if.master bus
`ifdef FIR_SEQ_STICKY_FLAGS_EN
  ,
  output flags_t             sticky_flags_o,
  input  logic               sticky_clr_i
`endif
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam int         WAIT_W   = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

  logic [1:0]            state_reg;
  logic [ADDR_WIDTH-1:0] tap_reg;
  logic [WAIT_W-1:0]     wait_reg;
  logic                  run_reg;
  logic                  m_valid_reg;
  logic [DATA_WIDTH-1:0] m_data_reg;
  flags_t                m_flags_reg;
  logic [DATA_WIDTH-1:0] coef_rd [FILTER_ORDER];
  logic [DATA_WIDTH-1:0] x_tap;
  logic                  accept;
  logic                  last_tap;
  logic                  last_wait;
  logic                  capture;
  logic                  coef_ok;
  flags_t                new_flags;

  assign bus.s_ready_o = run_reg & (state_reg == ST_IDLE) & ~m_valid_reg;
  assign accept        = bus.s_valid_i & bus.s_ready_o;
  assign last_tap      = (tap_reg == ADDR_WIDTH'(FILTER_ORDER - 1));
  assign last_wait     = (wait_reg == WAIT_W'(MAC_LATENCY - 1));
  assign capture       = (state_reg == ST_WAIT) & last_wait;
  assign new_flags     = pack_flags(bus.invalid_i, bus.overflow_i, bus.underflow_i);
  assign coef_ok       = bus.coef_we_i & (state_reg == ST_IDLE)
                       & ({1'b0, bus.coef_addr_i} < (ADDR_WIDTH+1)'(FILTER_ORDER));

  fir_delay_line #(
    .DEPTH      (FILTER_ORDER),
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (ADDR_WIDTH)
  ) u_delay (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .shift_en (accept),
    .shift_in (bus.s_data_i),
    .sel      (tap_reg),
    .tap      (x_tap)
  );

  // A write landing on the acceptance edge is already visible in ISSUE cycle 0.
  for (genvar gi = 0; gi < FILTER_ORDER; gi++) begin : g_coef
    logic [DATA_WIDTH-1:0] coef_reg;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        coef_reg <= DATA_WIDTH'(FP32_ZERO);
      end else if (coef_ok && (bus.coef_addr_i == ADDR_WIDTH'(gi))) begin
        coef_reg <= bus.coef_data_i;
      end
    end
    assign coef_rd[gi] = coef_reg;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      tap_reg   <= '0;
      wait_reg  <= '0;
      run_reg   <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg <= ST_ISSUE;
            tap_reg   <= '0;
          end
        end
        ST_ISSUE: begin
          if (last_tap) begin
            state_reg <= ST_WAIT;
            tap_reg   <= '0;
            wait_reg  <= '0;
          end else begin
            tap_reg <= tap_reg + ADDR_WIDTH'(1);
          end
        end
        ST_WAIT: begin
          if (last_wait) state_reg <= ST_IDLE;
          else           wait_reg  <= wait_reg + WAIT_W'(1);
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= DATA_WIDTH'(FP32_ZERO);
      m_flags_reg <= '0;
    end else if (capture) begin
      m_valid_reg <= 1'b1;
      m_data_reg  <= bus.y_i;
      m_flags_reg <= new_flags;
    end else if (m_valid_reg && bus.m_ready_i) begin
      m_valid_reg <= 1'b0;
    end
  end

`ifdef FIR_SEQ_STICKY_FLAGS_EN
  flags_t sticky_reg;

  // New flags win over a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sticky_reg <= '0;
    end else if (capture) begin
      sticky_reg <= (sticky_clr_i ? flags_t'(0) : sticky_reg) | new_flags;
    end else if (sticky_clr_i) begin
      sticky_reg <= '0;
    end
  end

  assign sticky_flags_o = sticky_reg;
`endif

  assign bus.mac_ce_o       = (state_reg == ST_ISSUE) | (state_reg == ST_WAIT);
  assign bus.fpopmode_bit_o = ((state_reg == ST_ISSUE) & (tap_reg != '0)) | (state_reg == ST_WAIT);
  assign bus.x_o            = (state_reg == ST_ISSUE) ? x_tap : '0;
  assign bus.h_o            = (state_reg == ST_ISSUE) ? coef_rd[tap_reg] : '0;
  assign bus.coef_busy_o    = (state_reg != ST_IDLE);
  assign bus.m_valid_o      = m_valid_reg;
  assign bus.m_data_o       = m_data_reg;
  assign bus.m_invalid_o    = m_flags_reg[2];
  assign bus.m_overflow_o   = m_flags_reg[1];
  assign bus.m_underflow_o  = m_flags_reg[0];

endmodule
